// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done operation port of the serial subtractor; master is the controller side.
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

  modport master (
    output start, x, y,
    input  busy, done, diff
  );

  modport slave (
    input  start, x, y,
    output busy, done, diff
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: two cascaded half-subtractor stages, borrows merged by an OR.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // first stage: a - b
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // second stage: (a - b) - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial x - y, LSB first, one full-subtractor step per clock; result is {final_borrow, difference}.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] xs_reg,     xs_next;
  logic [WIDTH-1:0] ys_reg,     ys_next;
  logic [WIDTH-1:0] res_reg,    res_next;
  logic             borrow_reg, borrow_next;
  logic [CW-1:0]    cnt_reg,    cnt_next;
  logic [WIDTH:0]   diff_reg,   diff_next;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .a    (xs_reg[0]),
    .b    (ys_reg[0]),
    .bin  (borrow_reg),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      xs_reg     <= '0;
      ys_reg     <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      xs_reg     <= xs_next;
      ys_reg     <= ys_next;
      res_reg    <= res_next;
      borrow_reg <= borrow_next;
      cnt_reg    <= cnt_next;
      diff_reg   <= diff_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    xs_next     = xs_reg;
    ys_next     = ys_reg;
    res_next    = res_reg;
    borrow_next = borrow_reg;
    cnt_next    = cnt_reg;
    diff_next   = diff_reg;

    case (state_reg)
      IDLE, DONE: begin
        // DONE accepts a new start too, so back-to-back operations need no idle cycle
        if (bus.start) begin
          xs_next     = bus.x;
          ys_next     = bus.y;
          res_next    = '0;
          borrow_next = 1'b0;
          cnt_next    = '0;
          state_next  = SHIFT;
        end else begin
          state_next  = IDLE;
        end
      end
      SHIFT: begin
        xs_next     = xs_reg >> 1;
        ys_next     = ys_reg >> 1;
        res_next    = {fs_d, res_reg[WIDTH-1:1]};
        borrow_next = fs_bout;
        cnt_next    = cnt_reg + CW'(1);
        // last bit: publish the full result in the same edge, borrow becomes the sign
        if (cnt_reg == LAST) begin
          diff_next  = {fs_bout, fs_d, res_reg[WIDTH-1:1]};
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == SHIFT);
  assign bus.done = (state_reg == DONE);
  assign bus.diff = diff_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random and exhaustive sweeps vs. an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 5;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction, reduced to W+1 bits two's complement.
  function automatic logic [W:0] model(input int a, input int b);
    int r;
    r = a - b;
    return r[W:0];
  endfunction

  // Issue one operation and wait for done; n = edges from the accepting edge to done (inclusive).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W:0] d, output int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = a;
    bus.y     = b;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = W'($urandom);
    bus.y     = W'($urandom);
    while (bus.done !== 1'b1 && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    d = bus.diff;
    $display("op x=%0d y=%0d diff=%b edges=%0d", a, b, d, n);
  endtask

  task automatic test_reset();
    logic [W:0] d;
    int n;
    run_op(5'd7, 5'd1, d, n);
    checks++; if (d !== 6'b000110) begin fails++; $display("FAIL reset_pre_diff got=%b exp=000110", d); end
    @(negedge clk);
    bus.start = 1'b1; bus.x = 5'd9; bus.y = 5'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.diff !== 6'b000000) begin fails++; $display("FAIL reset_diff got=%b exp=000000", bus.diff); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL reset_idle busy=%b done=%b exp=0/0", bus.busy, bus.done); end
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus.start = 1'b1; bus.x = 5'b00101; bus.y = 5'b00011;
    for (int e = 0; e < 7; e++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (e < 5) begin
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin fails++; $display("FAIL lat_busy edge=%0d busy=%b done=%b exp=1/0", e + 1, bus.busy, bus.done); end
      end else if (e == 5) begin
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL lat_done edge=6 done=%b busy=%b exp=1/0", bus.done, bus.busy); end
        checks++; if (bus.diff !== 6'b000010) begin fails++; $display("FAIL lat_diff got=%b exp=000010", bus.diff); end
      end else begin
        checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL lat_single_pulse done=%b exp=0", bus.done); end
      end
    end
    $display("op x=5 y=3 latency sequence checked");
  endtask

  task automatic test_corners();
    logic [W:0] d;
    int n;
    run_op(5'b00000, 5'b00001, d, n);
    checks++; if (d !== 6'b111111 || n !== 6) begin fails++; $display("FAIL corner_0m1 got=%b edges=%0d exp=111111/6", d, n); end
    run_op(5'b11111, 5'b11111, d, n);
    checks++; if (d !== 6'b000000 || n !== 6) begin fails++; $display("FAIL corner_eq got=%b edges=%0d exp=000000/6", d, n); end
    run_op(5'b11111, 5'b00000, d, n);
    checks++; if (d !== 6'b011111 || n !== 6) begin fails++; $display("FAIL corner_max got=%b edges=%0d exp=011111/6", d, n); end
  endtask

  task automatic test_ignore_and_abort();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.x = 5'd10; bus.y = 5'd3;
    @(posedge clk);
    n = 1;
    // pulse start with other operands during SHIFT
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.start = k[0] ? 1'b0 : 1'b1;
      bus.x = W'($urandom); bus.y = W'($urandom);
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    $display("op x=10 y=3 with ignored starts diff=%b edges=%0d", bus.diff, n);
    checks++; if (n !== 6) begin fails++; $display("FAIL ignore_edges got=%0d exp=6", n); end
    checks++; if (bus.diff !== model(10, 3)) begin fails++; $display("FAIL ignore_diff got=%b exp=%b", bus.diff, model(10, 3)); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_idle done=%b busy=%b exp=0/0", bus.done, bus.busy); end

    // abort in the third SHIFT cycle
    bus.start = 1'b1; bus.x = 5'd20; bus.y = 5'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.diff !== 6'b000000) begin fails++; $display("FAIL abort_diff got=%b exp=000000", bus.diff); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL abort_quiet cycle=%0d done=%b busy=%b exp=0/0", c, bus.done, bus.busy); end
    end
    $display("abort mid-SHIFT checked");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.start = 1'b1; bus.x = 5'b10000; bus.y = 5'b00001;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 0) begin
        bus.x = 5'b00001; bus.y = 5'b10000;
      end
      if (e == 6) bus.start = 1'b0;
      if (e == 5) begin
        checks++; if (bus.done !== 1'b1 || bus.diff !== 6'b001111) begin fails++; $display("FAIL b2b_first done=%b diff=%b exp=1/001111", bus.done, bus.diff); end
      end else if (e >= 6 && e <= 10) begin
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.diff !== 6'b001111) begin fails++; $display("FAIL b2b_hold edge=%0d busy=%b done=%b diff=%b exp=1/0/001111", e, bus.busy, bus.done, bus.diff); end
      end else if (e == 11) begin
        checks++; if (bus.done !== 1'b1 || bus.diff !== 6'b110001) begin fails++; $display("FAIL b2b_second done=%b diff=%b exp=1/110001", bus.done, bus.diff); end
      end
    end
    $display("back-to-back 16-1 then 1-16 checked");
  endtask

  task automatic test_random();
    logic [W:0] d;
    int n;
    logic [W-1:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op(a, b, d, n);
      checks++; if (d !== model(a, b) || n !== 6) begin fails++; $display("FAIL random x=%0d y=%0d got=%b edges=%0d exp=%b/6", a, b, d, n, model(a, b)); end
    end
  endtask

  task automatic test_sweep();
    logic [W:0] d;
    int n;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        run_op(W'(a), W'(b), d, n);
        checks++; if (d !== model(a, b) || n !== 6) begin fails++; $display("FAIL sweep x=%0d y=%0d got=%b edges=%0d exp=%b/6", a, b, d, n, model(a, b)); end
      end
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    reset     = 1'b1;
    #12;
    reset     = 1'b0;
    test_reset();
    test_latency();
    test_corners();
    test_ignore_and_abort();
    test_back_to_back();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor that computes diff = x - y, processing one bit per clock, LSB first, through a single full-subtractor cell.
It is the inverse-direction counterpart of the team's combinational ripple-carry adder: subtraction instead of addition, and serial instead of parallel.
It uses a start/busy/done handshake so a controller can issue operations back-to-back.
The result is WIDTH+1 bits wide; its MSB is the final borrow, which makes it the two's-complement sign.

Parameters:
WIDTH, 5, operand width in bits (legal range 2..16).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled on the rising edge of clk.
x  input  WIDTH  minuend; sampled only on the edge that accepts start.
y  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse; diff is valid from this cycle onward.
diff  output  WIDTH+1  result {final_borrow, (x-y) mod 2^WIDTH}; equals x-y as a signed WIDTH+1-bit value.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0. Internal operand, result, borrow and bit-counter registers are also cleared to 0.
- States:
  - IDLE: start=1 → latch x and y into shift registers, clear borrow and counter → SHIFT.
  - SHIFT:
    - Each edge applies full_subtractor to (xs[0], ys[0], borrow).
    - The difference bit shifts into the result register from the MSB side. xs and ys shift right. borrow updates. counter increments.
    - On the edge where counter reaches WIDTH-1 → DONE. That same edge loads diff={borrow_out, result}.
  - DONE: done=1 for exactly one cycle.
    - start=1 → accept a new operation (same action as from IDLE) → SHIFT.
    - Otherwise → IDLE.
- busy=1 exactly while state=SHIFT.
- Latency: start accepted at edge E0. busy is high after E0 through edge E_WIDTH. done=1 and diff valid in the cycle after E_WIDTH. Total: WIDTH+1 edges from start to done.
- start while in SHIFT is ignored: no restart, no queueing, and x/y are not resampled.
- diff holds its value until the next DONE entry. It does not change during a later SHIFT.
- Back-to-back: start held high through DONE gives a new operation with no idle cycle; the next done comes WIDTH+1 edges later.
- Reset asserted mid-SHIFT aborts immediately. After reset deasserts, the block sits in IDLE and done does not pulse.
- Arithmetic is unsigned operands with a signed result:
  - x≥y → diff[WIDTH]=0.
  - x<y → diff[WIDTH]=1 and diff = 2^(WIDTH+1) - (y-x).
- full_subtractor equations: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).

Decomposition:
- Shared package (sub_pkg): state enum {IDLE, SHIFT, DONE} with 2-bit encoding; DEFAULT_WIDTH=5.
- Sub-module full_subtractor (combinational): ports a, b, bin, d, bout. It is built from two half-subtractor stages plus an OR, mirroring the adder's half/full cell structure.
- The counter is $clog2(WIDTH) bits wide.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle → busy=0, done=0, diff=000000 immediately, without waiting for a clock edge.
2. x=00101, y=00011, start one cycle → busy high for 5 cycles, then done pulses once with diff=000010. Check done arrives exactly 6 edges after start.
3. x=00000, y=00001 → diff=111111 (-1). Also x=11111, y=11111 → diff=000000. Also x=11111, y=00000 → diff=011111.
4. Abort and ignore: start pulses during SHIFT with different x/y → ignored, and the result matches the original operands. Separately, reset asserted in the third SHIFT cycle → IDLE, no done pulse, diff=0.
5. Back-to-back: hold start=1 with x=10000,y=00001 and then x=00001,y=10000 → two done pulses 6 edges apart with diff=001111 then diff=110001. diff must hold 001111 through the second SHIFT.
6. Exhaustive sweep: all 1024 (x,y) pairs for WIDTH=5 → diff equals the signed 6-bit value of x-y for every pair, compared against a reference model.
